spi_txn_arbiter: RTL
====================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one spi_master among NREQ byte-stream requesters; round-robin grant per frame.
//  Drives the master's CS_in/data_in; watches TX_DONE (sclk domain, synchronised here);
//  returns p_out bytes. Handles CS setup/hold/gap timing and aborts stalled frames.
// PARAMETERS
//  NREQ      2      number of requesters (2..8)
//  IDW       1      width of id fields, clog2(NREQ), min 1
//  SETUP_CYC 4      clk cycles CS low before first byte counts
//  HOLD_CYC  4      clk cycles CS held low after last done
//  GAP_CYC   8      min clk cycles CS high between frames
//  TIMEOUT   255    clk cycles in XFER without done edge -> abort (8-bit counter)
// PORTS
//  clk        in   1        system clock (same clk as spi_master)
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   NREQ     requester i has a byte on req_data[i*8+:8]
//  req_data   in   NREQ*8   byte to send, per requester
//  req_last   in   NREQ     byte is last of frame
//  req_ready  out  NREQ     1-cycle pulse: byte of requester i accepted
//  rsp_valid  out  1        1-cycle pulse: received byte valid
//  rsp_data   out  8        received byte (captured p_out)
//  rsp_id     out  IDW      requester owning rsp_data
//  rsp_last   out  1        rsp byte is final of frame
//  spi_cs     out  1        to master CS_in; 1 = deselected
//  spi_data   out  8        to master data_in
//  spi_done   in   1        master TX_DONE (asynchronous to clk)
//  spi_rx     in   8        master p_out
//  busy       out  1        state != IDLE
//  grant_id   out  IDW      current/last granted requester
//  err_tmo    out  1        1-cycle pulse on timeout abort
//  err_undr   out  1        1-cycle pulse: frame ended on underrun
// BEHAVIOUR
//  Reset: spi_cs=1, spi_data=0, all pulses/req_ready=0, rsp_*=0, busy=0, grant_id=0,
//   rr pointer=0, state=IDLE, all counters 0. Reset mid-frame: CS rises immediately.
//  done_sync: 2-flop synchroniser on spi_done; done_evt = rising edge of synced level.
//  States: IDLE, SETUP, XFER, HOLD, GAP, ABORT.
//  IDLE: if any req_valid, grant first i with req_valid, searching from rr ptr upward
//   (wraps); grant_id<=i; latch req_data[i], last flag; req_ready[i] pulse; spi_cs<=0;
//   go SETUP. Decision + accept in one cycle.
//  SETUP: count SETUP_CYC, then XFER. spi_data valid from first SETUP cycle.
//  XFER: on done_evt: rsp_data<=spi_rx, rsp_id<=grant_id, rsp_valid pulse,
//   rsp_last=latched last or underrun. Then:
//   latched last=1 -> HOLD; else req_valid[grant] -> latch next byte, req_ready pulse,
//   stay XFER (same cycle as done_evt); else err_undr pulse, HOLD.
//   Timeout counter cleared on entry and each done_evt; hits TIMEOUT -> ABORT.
//  HOLD: HOLD_CYC cycles, then spi_cs<=1, GAP.
//  ABORT: spi_cs<=1, err_tmo pulse, no rsp; go GAP.
//  GAP: GAP_CYC cycles with CS high; rr ptr<=grant_id+1 (mod NREQ); -> IDLE.
//  Requesters must hold req_valid/data until req_ready; req_ready only to grantee.
//  req_valid change of non-grantee never affects current frame.
//  A done_evt in SETUP/HOLD/GAP/IDLE is ignored (no rsp).
//  Frame length unbounded; rsp count per frame = bytes accepted (minus abort).
// TESTING
//  T1 rst, req0 sends 8'hA5 last, miso loopback -> spi_cs low, 8 sclk, rsp_data=A5,
//     rsp_id=0, rsp_last=1, spi_cs high after HOLD_CYC, then GAP_CYC, busy=0.
//  T2 req0 and req1 valid together, 1 byte each, repeat x3 -> grants 0,1,0,1,0,1.
//  T3 req1 frame 3 bytes 11,22,33 (last on 33) -> 3 req_ready, 3 rsp, CS low throughout,
//     only third rsp has rsp_last=1.
//  T4 req0 2-byte frame, req_valid dropped after byte 1 -> err_undr pulse, rsp_last=1
//     on byte 1, CS high after HOLD.
//  T5 spi_done tied 0 -> err_tmo pulse TIMEOUT cycles after XFER entry, CS=1, no rsp.
//  T6 rst asserted mid-byte -> spi_cs=1 same cycle, all outputs reset values; new
//     frame afterward completes normally.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one spi_master between NREQ byte-stream requesters.
// A frame is granted round-robin, its bytes are fed to the master one per
// TX_DONE, and the received bytes are returned tagged with the owner id.
// CS setup, hold and inter-frame gap are timed here; a frame whose master
// never reports completion is aborted after TIMEOUT cycles.
//
// Handshake: a requester raises req_valid with req_data/req_last and holds
// them until req_ready pulses for exactly one cycle; that pulse means the
// byte was taken. rsp_valid is a one-cycle pulse with no back-pressure.
module spi_txn_arbiter #(
  parameter int NREQ      = 2,
  parameter int IDW       = 1,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_last,
  output logic              spi_cs,
  output logic [7:0]        spi_data,
  input  logic              spi_done,
  input  logic [7:0]        spi_rx,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              err_tmo,
  output logic              err_undr,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  state_t         state;
  logic           sync1, sync2, sync2_d;
  logic           done_evt;
  logic [IDW-1:0] rr_ptr;
  logic           last_q;
  logic [7:0]     cnt;
  logic [7:0]     tmo_cnt;
  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;
  logic [7:0]     data_arr [NREQ];

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign done_evt  = sync2 & ~sync2_d;

  // Bring TX_DONE into the clk domain and keep the previous level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= spi_done;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Unpack the flat request bus into one byte per requester
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*8 +: 8];
    end
  end

  // Pick the first valid requester at or above rr_ptr, wrapping; the lowest offset wins
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Frame sequencer: grant, CS timing, byte feed, response capture, abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      spi_cs    <= 1'b1;
      spi_data  <= 8'h00;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      last_q    <= 1'b0;
      cnt       <= 8'd0;
      tmo_cnt   <= 8'd0;
      err_tmo   <= 1'b0;
      err_undr  <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= 1'b0;
      err_tmo   <= 1'b0;
      err_undr  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id  <= sel;
            spi_data  <= data_arr[sel];
            last_q    <= req_last[sel];
            req_ready <= NREQ'(1) << sel;
            spi_cs    <= 1'b0;
            cnt       <= 8'd0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == 8'(SETUP_CYC - 1)) begin
            cnt     <= 8'd0;
            tmo_cnt <= 8'd0;
            state   <= S_XFER;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (done_evt) begin
            rsp_valid <= 1'b1;
            rsp_data  <= spi_rx;
            rsp_id    <= grant_id;
            tmo_cnt   <= 8'd0;
            if (last_q) begin
              rsp_last <= 1'b1;
              cnt      <= 8'd0;
              state    <= S_HOLD;
            end else if (req_valid[grant_id]) begin
              rsp_last  <= 1'b0;
              spi_data  <= data_arr[grant_id];
              last_q    <= req_last[grant_id];
              req_ready <= NREQ'(1) << grant_id;
            end else begin
              // Requester ran dry mid-frame: close the frame on this byte
              rsp_last <= 1'b1;
              err_undr <= 1'b1;
              cnt      <= 8'd0;
              state    <= S_HOLD;
            end
          end else if ({1'b0, tmo_cnt} + 9'd1 == 9'(TIMEOUT)) begin
            state <= S_ABORT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt == 8'(HOLD_CYC - 1)) begin
            spi_cs <= 1'b1;
            cnt    <= 8'd0;
            state  <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ABORT: begin
          spi_cs  <= 1'b1;
          err_tmo <= 1'b1;
          cnt     <= 8'd0;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (cnt == 8'(GAP_CYC - 1)) begin
            rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
            cnt    <= 8'd0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          spi_cs <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
